fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch and PC-update stage; sits directly upstream of the combinational decoder.
- Owns the architectural PC and drives the synchronous-read instruction memory.
- Presents one instruction at a time to the decoder, then consumes the decoder's sel_pc/imm plus the ALU result to compute the next PC.
- Multi-cycle, non-pipelined: 2 cycles per instruction, plus any stall cycles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_ADDR_BITS, 11, word-address width of instruction memory.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the current instruction in EXEC; no PC update.
- sel_pc  in  2  next-PC select from decoder: 00 hold/halt, 01 PC+4, 10 PC+4+imm*4, 11 ALU.
- imm  in  16  decoder immediate; signed branch offset in words.
- alu_out  in  32  ALU result; jump target.
- imem_addr  out  IMEM_ADDR_BITS  word address to instruction memory.
- imem_rdata  in  32  instruction memory read data; valid 1 cycle after imem_addr.
- inst  out  32  instruction to decoder.
- inst_valid  out  1  inst is a live instruction; downstream gates register/memory writes with it.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, used for the link value.
- halted  out  1  stage is stopped.
- retire_count  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset values (applied on the clock edge where reset=1, regardless of state):
  - state=FETCH, pc=RESET_PC, halted=0, inst_valid=0.
  - retire_count=0.
- Addressing:
  - imem_addr = pc[IMEM_ADDR_BITS+1:2] in every state.
  - The address is held stable for the whole EXEC period, so imem_rdata stays stable through stalls.
- inst output:
  - inst = imem_rdata when inst_valid=1.
  - Otherwise inst = 32'h0000_DEAD, which the decoder treats as a no-op (no writes, sel_pc=00).
- pc_plus4 = pc + 32'd4, combinational, mod 2^32.
- FSM states: FETCH, EXEC, HALT.
- FETCH:
  - inst_valid=0; sel_pc is ignored.
  - Next state is always EXEC.
- EXEC:
  - inst_valid=1.
  - If stall=1: stay in EXEC; pc unchanged.
  - If stall=0 and sel_pc=00: go to HALT; pc unchanged.
  - Otherwise: pc <= next_pc and go to FETCH.
- next_pc (all arithmetic 32-bit, wraps mod 2^32):
  - 01: pc+4.
  - 10: pc+4 + (sign_extend(imm) << 2).
  - 11: {alu_out[31:2], 2'b00}; low bits are forced to zero so pc stays word-aligned.
- HALT:
  - halted=1, inst_valid=0.
  - Stays in HALT until reset; stall is ignored.
- Simultaneous reset and stall: reset wins.
- Reset in any state restarts at FETCH on the next cycle.
- Latency:
  - First inst_valid occurs in the 2nd cycle after reset deassertion.
  - Unstalled throughput is 1 instruction per 2 cycles.
- imem_addr truncation: PC bits above IMEM_ADDR_BITS+1 are ignored; the memory aliases.

Optional Feature:
- Macro: FETCH_RETIRE_CNT_EN.
- Defined:
  - retire_count increments by 1 on every EXEC cycle with stall=0 and sel_pc!=00.
  - Wraps 32'hFFFF_FFFF -> 0.
  - Reset clears it to 0.
- Undefined: retire_count tied to 32'h0; no counter flops.

Test Plan:
- Reset with RESET_PC=0, imem[0]=ALU op (sel_pc=01):
  - Cycle 1: imem_addr=0, inst_valid=0, inst=32'h0000_DEAD.
  - Cycle 2: inst_valid=1, inst=imem[0].
  - Cycle 3: pc=4, FETCH.
- Branch at pc=0x10 with sel_pc=10, imm=16'hFFFE -> pc becomes 0x0C.
- Branch at pc=0x10 with sel_pc=10, imm=16'h0003 -> pc becomes 0x20.
- Jump with sel_pc=11, alu_out=32'h0000_0103 -> pc becomes 0x100.
  - During that EXEC, pc_plus4 = pc+4.
- stall=1 for 3 EXEC cycles:
  - inst_valid stays 1; inst, pc and imem_addr stay constant.
  - retire_count is unchanged.
  - Release stall -> advance exactly once; retire_count +1 with FETCH_RETIRE_CNT_EN.
- sel_pc=00 in EXEC:
  - Next cycle halted=1, inst_valid=0, inst=32'h0000_DEAD.
  - Holds there for 10 cycles with stall toggling.
  - Assert reset -> pc=RESET_PC, halted=0, FETCH.
- Wrap-around:
  - pc=32'hFFFF_FFFC with sel_pc=01 -> pc becomes 0.
  - retire_count preloaded to 32'hFFFF_FFFF by retiring instructions (or by force) -> becomes 0 after one retire.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch and PC update, two cycles per instruction plus stalls
// Ports: clk/reset (sync, active-high); stall holds EXEC; sel_pc/imm/alu_out choose next PC;
// imem_addr/imem_rdata drive a synchronous-read instruction memory; inst/inst_valid feed
// the decoder; pc/pc_plus4 expose the PC; halted flags the stopped stage; retire_count
// counts retired instructions when FETCH_RETIRE_CNT_EN is defined, else reads 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_ADDR_BITS = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [1:0]                sel_pc,
  input  logic [15:0]               imm,
  input  logic [31:0]               alu_out,
  output logic [IMEM_ADDR_BITS-1:0] imem_addr,
  input  logic [31:0]               imem_rdata,
  output logic [31:0]               inst,
  output logic                      inst_valid,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  output logic                      halted,
  output logic [31:0]               retire_count
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t r_state, w_next;
  logic [31:0] r_pc, w_next_pc, w_branch;
  logic w_adv, w_unused;
  always_ff @(posedge clk)
    r_state <= reset ? FETCH : w_next;
  always_comb begin
    w_next = r_state == FETCH ? EXEC :
             r_state == EXEC  ? (stall ? EXEC : sel_pc == 2'b00 ? HALT : FETCH) : HALT;
  end
  always_comb begin
    inst_valid = r_state == EXEC;
    halted     = r_state == HALT;
    inst       = inst_valid ? imem_rdata : 32'h0000_DEAD;
  end
  assign w_adv     = r_state == EXEC && !stall && sel_pc != 2'b00;
  assign pc_plus4  = r_pc + 32'd4;
  assign w_branch  = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  assign w_next_pc = sel_pc == 2'b01 ? pc_plus4 :
                     sel_pc == 2'b10 ? w_branch :
                     sel_pc == 2'b11 ? {alu_out[31:2], 2'b00} : r_pc;
  assign w_unused  = &{1'b0, alu_out[1:0]};
  always_ff @(posedge clk)
    if (reset) r_pc <= RESET_PC;
    else if (w_adv) r_pc <= w_next_pc;
  assign pc        = r_pc;
  assign imem_addr = r_pc[IMEM_ADDR_BITS+1:2];
`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] r_retire_count;
  always_ff @(posedge clk)
    if (reset) r_retire_count <= 32'd0;
    else if (w_adv) r_retire_count <= r_retire_count + 32'd1;
  assign retire_count = r_retire_count;
`else
  assign retire_count = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a behavioural model
module tb_fetch_stage;
  localparam int S_FETCH = 0, S_EXEC = 1, S_HALT = 2;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0;
  logic [1:0] sel_pc = 2'b00;
  logic [15:0] imm = '0;
  logic [31:0] alu_out = '0, imem_rdata, inst, pc, pc_plus4, retire_count;
  logic [10:0] imem_addr;
  logic inst_valid, halted;
  logic [31:0] mem [2048];
  int n_cmp = 0, n_fail = 0, m_st = S_FETCH;
  logic [31:0] m_pc = '0, m_rc = '0, held;
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .sel_pc(sel_pc), .imm(imm), .alu_out(alu_out),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .pc_plus4(pc_plus4), .halted(halted), .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= mem[imem_addr];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic [31:0] erc;
`ifdef FETCH_RETIRE_CNT_EN
    erc = m_rc;
`else
    erc = 32'h0;
`endif
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("imem_addr", {21'h0, imem_addr}, {21'h0, m_pc[12:2]});
    chk("inst_valid", {31'h0, inst_valid}, {31'h0, m_st == S_EXEC});
    chk("halted", {31'h0, halted}, {31'h0, m_st == S_HALT});
    chk("inst", inst, m_st == S_EXEC ? mem[m_pc[12:2]] : 32'h0000_DEAD);
    chk("retire_count", retire_count, erc);
  endtask
  task automatic cyc(input logic rs, input logic st, input logic [1:0] s,
                     input logic [15:0] im, input logic [31:0] a);
    int simm;
    reset = rs; stall = st; sel_pc = s; imm = im; alu_out = a;
    @(posedge clk);
    simm = int'($signed(im));
    if (rs) begin
      m_st = S_FETCH; m_pc = 32'h0; m_rc = 32'h0;
    end else if (m_st == S_FETCH) m_st = S_EXEC;
    else if (m_st == S_EXEC && !st) begin
      if (s == 2'b00) m_st = S_HALT;
      else begin
        m_pc = s == 2'b01 ? m_pc + 4 : s == 2'b10 ? m_pc + 4 + 32'(simm * 4) : a & ~32'h3;
        m_rc = m_rc + 1;
        m_st = S_FETCH;
      end
    end
    #1;
    check_all();
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    cyc(1, 1, 2'b01, 0, 0);
    cyc(0, 0, 2'b01, 0, 0);
    chk("first_valid", {31'h0, inst_valid}, 32'h1);
    chk("first_inst", inst, mem[0]);
    cyc(0, 0, 2'b01, 0, 0);
    chk("after_first_pc", pc, 32'h4);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b11, 0, 32'h10);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b10, 16'hFFFE, 0);
    chk("branch_back", pc, 32'h0C);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b11, 0, 32'h10);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b10, 16'h0003, 0);
    chk("branch_fwd", pc, 32'h20);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b11, 0, 32'h0000_0103);
    chk("jump_align", pc, 32'h100);
    cyc(0, 0, 2'b00, 0, 0);
    held = inst;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 2'($urandom_range(0, 3)), 16'($urandom), $urandom);
      chk("stall_inst", inst, held);
    end
    cyc(0, 0, 2'b01, 0, 0);
    chk("stall_release", pc, 32'h104);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b11, 0, 32'hFFFF_FFFF);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b01, 0, 0);
    chk("pc_wrap", pc, 32'h0);
`ifdef FETCH_RETIRE_CNT_EN
    cyc(0, 0, 2'b00, 0, 0);
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_count;
    m_rc = 32'hFFFF_FFFF;
    cyc(0, 0, 2'b01, 0, 0);
    chk("rc_wrap", retire_count, 32'h0);
`endif
    cyc(0, 0, 2'b01, 0, 0);
    cyc(0, 0, 2'b00, 0, 0);
    chk("halt_enter", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 10; i++) cyc(0, 1'(i), 2'($urandom_range(0, 3)), 16'($urandom), $urandom);
    chk("halt_hold", inst, 32'h0000_DEAD);
    cyc(1, 1, 2'b01, 0, 0);
    chk("halt_reset_pc", pc, 32'h0);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 30),
          $urandom_range(0, 19) == 0 ? 2'b00 : 2'($urandom_range(1, 3)), 16'($urandom), $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
